// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave fronting a bank of NUM_REGS read/write registers with
// byte-lane write strobes and independent, single-outstanding read and
// write channels.
// Optional feature macro: AXIL_SLVERR_EN (out-of-range accesses answer SLVERR
// instead of OKAY).
module axi4_lite_regfile_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                      i_ACLK,
  input  logic                      i_ARESETN,
  input  logic [ADDR_WIDTH-1:0]     i_M_AWADDR,
  input  logic [2:0]                i_M_AWPROT,
  input  logic                      i_M_AWVALID,
  output logic                      o_S_AWREADY,
  input  logic [DATA_WIDTH-1:0]     i_M_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   i_M_WSTRB,
  input  logic                      i_M_WVALID,
  output logic                      o_S_WREADY,
  output logic [1:0]                o_S_BRESP,
  output logic                      o_S_BVALID,
  input  logic                      i_M_BREADY,
  input  logic [ADDR_WIDTH-1:0]     i_M_ARADDR,
  input  logic [2:0]                i_M_ARPROT,
  input  logic                      i_M_ARVALID,
  output logic                      o_S_ARREADY,
  output logic [DATA_WIDTH-1:0]     o_S_RDATA,
  output logic [1:0]                o_S_RRESP,
  output logic                      o_S_RVALID,
  input  logic                      i_M_RREADY
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned ADDRLSB = $clog2(STRB_W);
  localparam int unsigned IDX_W   = ADDR_WIDTH - ADDRLSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs_c;
  assign unused_inputs_c = ^{i_M_AWPROT, i_M_ARPROT,
                             i_M_AWADDR[ADDRLSB-1:0], i_M_ARADDR[ADDRLSB-1:0]};

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q,  aw_idx_d;
  logic                  w_held_q,  w_held_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;

  logic                  commit_c;
  logic                  wr_in_range_c;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  assign commit_c      = aw_held_q && w_held_q;
  assign wr_in_range_c = 32'(aw_idx_q) < NUM_REGS;

  // Capture AW/W independently, commit once both are held, retire on B handshake.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;

    if (i_M_AWVALID && awready_q) begin
      aw_held_d = 1'b1;
      aw_idx_d  = i_M_AWADDR[ADDR_WIDTH-1:ADDRLSB];
    end
    if (i_M_WVALID && wready_q) begin
      w_held_d = 1'b1;
      wdata_d  = i_M_WDATA;
      wstrb_d  = i_M_WSTRB;
    end

    if (commit_c) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range_c ? RESP_OKAY : RESP_OOR;
    end else if (bvalid_q && i_M_BREADY) begin
      bvalid_d  = 1'b0;
      bresp_d   = RESP_OKAY;
    end

    // Readies reopen on the same edge the response retires.
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d  && !bvalid_d;
  end

  // Write channel registers.
  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  // Register bank: strobed byte-lane update on commit; out-of-range index hits nothing.
  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        if (commit_c && (aw_idx_q == IDX_W'(r))) begin
          for (int k = 0; k < int'(STRB_W); k++) begin
            if (wstrb_q[k]) begin
              regs_q[r][8*k +: 8] <= wdata_q[8*k +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q,  arready_d;
  logic                  rvalid_q,   rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [1:0]            rresp_q,    rresp_d;

  logic [IDX_W-1:0]      ar_idx_c;
  logic                  ar_in_range_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  assign ar_idx_c      = i_M_ARADDR[ADDR_WIDTH-1:ADDRLSB];
  assign ar_in_range_c = 32'(ar_idx_c) < NUM_REGS;

  // Register select; an out-of-range index matches no entry and reads as zero.
  always_comb begin
    rd_word_c = '0;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (ar_idx_c == IDX_W'(r)) begin
        rd_word_c = regs_q[r];
      end
    end
  end

  // Read FSM: accept AR in idle, hold RDATA/RRESP until the R handshake.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;

    case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (i_M_ARVALID && arready_q) begin
          rd_state_d = RD_RESP;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_word_c;
          rresp_d    = ar_in_range_c ? RESP_OKAY : RESP_OOR;
        end
      end
      RD_RESP: begin
        if (i_M_RREADY) begin
          rd_state_d = RD_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
          rdata_d    = '0;
          rresp_d    = RESP_OKAY;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        arready_d  = 1'b0;
        rvalid_d   = 1'b0;
        rdata_d    = '0;
        rresp_d    = RESP_OKAY;
      end
    endcase
  end

  // Read channel registers.
  always_ff @(posedge i_ACLK or negedge i_ARESETN) begin
    if (!i_ARESETN) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign o_S_AWREADY = awready_q;
  assign o_S_WREADY  = wready_q;
  assign o_S_BVALID  = bvalid_q;
  assign o_S_BRESP   = bresp_q;
  assign o_S_ARREADY = arready_q;
  assign o_S_RVALID  = rvalid_q;
  assign o_S_RDATA   = rdata_q;
  assign o_S_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Self-checking bench for axi4_lite_regfile_slave (default 32-bit, 16 regs).
// Honours AXIL_SLVERR_EN for the expected out-of-range response code.
module tb_axi4_lite_regfile_slave;

`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic        aclk;
  logic        aresetn;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference register file: plain array, in-range writes only.
  logic [31:0] model [16];

  axi4_lite_regfile_slave dut (
    .i_ACLK      (aclk),
    .i_ARESETN   (aresetn),
    .i_M_AWADDR  (awaddr),
    .i_M_AWPROT  (awprot),
    .i_M_AWVALID (awvalid),
    .o_S_AWREADY (awready),
    .i_M_WDATA   (wdata),
    .i_M_WSTRB   (wstrb),
    .i_M_WVALID  (wvalid),
    .o_S_WREADY  (wready),
    .o_S_BRESP   (bresp),
    .o_S_BVALID  (bvalid),
    .i_M_BREADY  (bready),
    .i_M_ARADDR  (araddr),
    .i_M_ARPROT  (arprot),
    .i_M_ARVALID (arvalid),
    .o_S_ARREADY (arready),
    .o_S_RDATA   (rdata),
    .o_S_RRESP   (rresp),
    .o_S_RVALID  (rvalid),
    .i_M_RREADY  (rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (idx < 16) model[idx] = (model[idx] & ~mask) | (d & mask);
  endtask

  function automatic logic [31:0] model_read(input int idx);
    return (idx < 16) ? model[idx] : 32'h0;
  endfunction

  // Full write transaction; BREADY held low for bhold cycles after BVALID.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bhold, output logic [1:0] resp, output int lat);
    int   n;
    int   acc;
    logic aw_done;
    logic w_done;
    logic hsa;
    logic hsw;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = (bhold == 0);
    aw_done = 1'b0;
    w_done  = 1'b0;
    n       = 0;
    acc     = cyc;
    while (!(aw_done && w_done) && n < 20) begin
      hsa = awvalid && awready;
      hsw = wvalid && wready;
      @(negedge aclk);
      n++;
      if (hsa) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hsw) begin wvalid = 1'b0; w_done = 1'b1; end
      acc = cyc;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("aw_w_accept", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("bvalid_seen", bvalid, 1'b1);
    lat  = cyc - acc;
    resp = bresp;
    for (int h = 0; h < bhold; h++) begin
      chk("b_hold", {bvalid, bresp, awready, wready}, {1'b1, resp, 2'b00});
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    chk("b_done", {bvalid, awready, wready}, 3'b011);
  endtask

  // Full read transaction; RREADY held low for rhold cycles after RVALID.
  task automatic axi_read(input logic [7:0] a, input int rhold,
                          output logic [31:0] d, output logic [1:0] resp, output int ar_cyc);
    int   n;
    logic hs;
    araddr  = a;
    arvalid = 1'b1;
    rready  = (rhold == 0);
    hs      = 1'b0;
    n       = 0;
    while (!hs && n < 20) begin
      hs = arready;
      @(negedge aclk);
      n++;
    end
    arvalid = 1'b0;
    ar_cyc  = cyc;
    chk("ar_accept", hs, 1'b1);
    chk("rvalid_lat", rvalid, 1'b1);
    d    = rdata;
    resp = rresp;
    for (int h = 0; h < rhold; h++) begin
      @(negedge aclk);
      chk("r_hold", {rvalid, rdata, rresp}, {1'b1, d, resp});
    end
    rready = 1'b1;
    @(negedge aclk);
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  a;
    logic [31:0] rd;
    logic [3:0]  rs;
    int          c;
    int          c0;
    int          lat;
    int          idx;

    aresetn = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    model_clear();
    #1 aresetn = 1'b0;

    // Reset values.
    repeat (3) @(negedge aclk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready",  wready,  1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid",  bvalid,  1'b0);
    chk("rst_rvalid",  rvalid,  1'b0);
    chk("rst_rdata",   rdata,   32'h0);
    chk("rst_bresp",   bresp,   2'b00);
    chk("rst_rresp",   rresp,   2'b00);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Read all registers back-to-back: zero data, OKAY, one read per 2 cycles.
    c0 = 0;
    c  = 0;
    for (int i = 0; i < 16; i++) begin
      a = 8'(i * 4);
      axi_read(a, 0, d, r, c);
      if (i == 0) c0 = c;
      chk("init_rdata", d, 32'h0);
      chk("init_rresp", r, 2'b00);
    end
    chk("read_rate", c - c0, 30);
    chk("rdata_cleared", rdata, 32'h0);

    // Byte-strobed overwrite.
    axi_write(8'h04, 32'hDEADBEEF, 4'b1111, 0, r, lat);
    model_write(1, 32'hDEADBEEF, 4'b1111);
    chk("strb_bresp1", r, 2'b00);
    chk("write_latency", lat, 1);
    axi_write(8'h04, 32'h00001122, 4'b0011, 0, r, lat);
    model_write(1, 32'h00001122, 4'b0011);
    chk("strb_bresp2", r, 2'b00);
    axi_read(8'h04, 0, d, r, c);
    chk("strb_rdata", d, 32'hDEAD1122);
    chk("strb_model", d, model_read(1));

    // W three cycles ahead of AW.
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("wfirst_ready", {wready, awready, bvalid}, 3'b010);
    repeat (2) @(negedge aclk);
    chk("wfirst_wait", {wready, awready, bvalid}, 3'b010);
    awaddr = 8'h08; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("wfirst_aw_cap", {bvalid, awready, wready}, 3'b000);
    @(negedge aclk);
    chk("wfirst_commit", {bvalid, bresp}, 3'b100);
    @(negedge aclk);
    chk("wfirst_reopen", {bvalid, awready, wready}, 3'b011);
    model_write(2, 32'hA5A5A5A5, 4'hF);
    axi_read(8'h08, 0, d, r, c);
    chk("wfirst_rdata", d, 32'hA5A5A5A5);

    // BREADY withheld for 5 cycles.
    axi_write(8'h0C, 32'h0BADF00D, 4'hF, 5, r, lat);
    model_write(3, 32'h0BADF00D, 4'hF);
    chk("bhold_bresp", r, 2'b00);
    axi_read(8'h0C, 2, d, r, c);
    chk("bhold_rdata", d, model_read(3));

    // Out-of-range access at index 16.
    axi_write(8'h40, 32'h12345678, 4'hF, 0, r, lat);
    chk("oor_bresp", r, EXP_OOR);
    axi_read(8'h40, 0, d, r, c);
    chk("oor_rdata", d, 32'h0);
    chk("oor_rresp", r, EXP_OOR);
    for (int i = 0; i < 16; i++) begin
      a = 8'(i * 4);
      axi_read(a, 0, d, r, c);
      chk("oor_unchanged", {d, r}, {model_read(i), 2'b00});
    end

    // Reset between AW capture and W arrival.
    awaddr = 8'h10; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("mid_aw_cap", {awready, wready}, 2'b01);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_async_drop", {awready, wready, arready, bvalid, rvalid}, 5'b00000);
    model_clear();
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("mid_readies", {awready, wready, arready}, 3'b111);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("mid_no_bvalid", bvalid, 1'b0);
    end
    axi_read(8'h10, 0, d, r, c);
    chk("mid_reg4", d, 32'h0);
    axi_read(8'h04, 0, d, r, c);
    chk("mid_reg1", d, 32'h0);

    // Randomized traffic against the model.
    for (int t = 0; t < 150; t++) begin
      idx = int'($urandom_range(0, 19));
      a   = {6'(idx), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) begin
        rd = $urandom;
        rs = 4'($urandom);
        axi_write(a, rd, rs, int'($urandom_range(0, 2)), r, lat);
        model_write(idx, rd, rs);
        chk("rnd_bresp", r, (idx < 16) ? 2'b00 : EXP_OOR);
      end else begin
        axi_read(a, int'($urandom_range(0, 2)), d, r, c);
        chk("rnd_rdata", d, model_read(idx));
        chk("rnd_rresp", r, (idx < 16) ? 2'b00 : EXP_OOR);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regfile_slave.md
# axi4_lite_regfile_slave

Parametrised AXI4-Lite slave fronting a bank of NUM_REGS memory-mapped read/write registers with byte-lane write strobes, independent read and write channels and optional error responses. Sits on the peripheral side of the AXI4-Lite interconnect. It replaces fixed single-bit handshake slaves as the standard control/status register block for new peripherals.

## Interface
- DATA_WIDTH, 32: data bus width; 32 or 64.
- ADDR_WIDTH, 8: byte address width.
- NUM_REGS, 16: register count, 1..2^(ADDR_WIDTH-ADDRLSB); ADDRLSB = log2(DATA_WIDTH/8).

- i_ACLK  in  1  clock; all logic on rising edge.
- i_ARESETN  in  1  reset; asynchronous, active-low.
- i_M_AWADDR  in  ADDR_WIDTH  write address.
- i_M_AWPROT  in  3  ignored.
- i_M_AWVALID / o_S_AWREADY  in/out  1  write-address handshake.
- i_M_WDATA  in  DATA_WIDTH  write data.
- i_M_WSTRB  in  DATA_WIDTH/8  byte enables.
- i_M_WVALID / o_S_WREADY  in/out  1  write-data handshake.
- o_S_BRESP  out  2  write response.
- o_S_BVALID / i_M_BREADY  out/in  1  write-response handshake.
- i_M_ARADDR  in  ADDR_WIDTH  read address.
- i_M_ARPROT  in  3  ignored.
- i_M_ARVALID / o_S_ARREADY  in/out  1  read-address handshake.
- o_S_RDATA  out  DATA_WIDTH  read data.
- o_S_RRESP  out  2  read response.
- o_S_RVALID / i_M_RREADY  out/in  1  read-data handshake.

## Operation
- All outputs registered. Reset (asynchronous assertion, synchronous release) clears all registers, all outputs and all internal hold flags to 0.
- Register index = addr[ADDR_WIDTH-1:ADDRLSB]; low ADDRLSB address bits ignored.
- Write path, one transaction outstanding:
  - AW and W are captured independently, in either order or in the same cycle, into hold registers with flags aw_held/w_held. AWREADY = !aw_held && !BVALID; likewise WREADY.
  - On the edge after both flags are set (commit): byte lane k of reg[idx] is written from WDATA lane k where WSTRB[k]=1. BVALID<=1, BRESP set, both flags cleared.
  - AWREADY/WREADY stay 0 until the edge on which BVALID&&BREADY; they return to 1 on that edge.
- Read path, one transaction outstanding:
  - Idle: ARREADY=1. On the AR handshake edge: ARREADY<=0, RDATA<=reg[idx], RRESP set, RVALID<=1.
  - On the R handshake edge: RVALID<=0, ARREADY<=1.
  - RDATA/RRESP hold stable while RVALID=1 && !RREADY. RDATA returns to 0 after the R handshake.
- Read and write channels are fully independent. A read sampling the same register on a write-commit edge returns the pre-write value.
- The out-of-range case (idx >= NUM_REGS) is governed by Configuration.

## Timing
- Write: AW and W accepted on edge N; commit and BVALID at edge N+1. With BREADY high, handshake at edge N+2 and AWREADY/WREADY high again from N+2. Peak rate is 1 write per 3 cycles.
- AW at edge N, W at edge N+k: commit at edge N+k+1.
- Read: AR accepted at edge N; RVALID high from edge N. With RREADY high, handshake at N+1. Peak rate is 1 read per 2 cycles.
- Reset mid-transaction: pending write is discarded, register contents are cleared, and VALID/READY outputs drop immediately (asynchronously).
- From the first edge after reset release, AWREADY/WREADY/ARREADY = 1.

## Configuration
- AXIL_SLVERR_EN defined: out-of-range write is discarded and returns BRESP=2'b10 (SLVERR). Out-of-range read returns RDATA=0, RRESP=2'b10.
- Undefined: out-of-range write is silently discarded with BRESP=2'b00. Out-of-range read returns RDATA=0, RRESP=2'b00.
- In-range accesses always return OKAY (2'b00).

## Test plan
- Reset then read all 16 registers (addr 0x00..0x3C) -> RDATA=0, RRESP=0 each, one read per 2 cycles with RREADY held high.
- Write 0xDEADBEEF to 0x04 with WSTRB=4'b1111, then write 0x00001122 with WSTRB=4'b0011 -> read 0x04 returns 0xDEAD1122, BRESP=0 both times.
- W presented 3 cycles before AW (addr 0x08, data 0xA5A5A5A5) -> WREADY drops after W capture, commit on the edge after AW, read 0x08 returns 0xA5A5A5A5.
- BREADY held low 5 cycles after BVALID -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout, both ready again on the handshake edge.
- Access 0x40 (idx 16) -> with AXIL_SLVERR_EN: BRESP=2'b10, RDATA=0, RRESP=2'b10, registers unchanged. Without it: both responses 2'b00.
- Assert i_ARESETN low between AW capture and W arrival -> no register changes, BVALID never asserts, readies return to 1 after release.
